token_controller_lanes: RTL and testbench
=========================================

Name: token_controller_lanes

Overview:
- Parametrised successor of the single-lane token controller.
- Drives the scheduler, the core SRAM (CSRAM) and NUM_LANES neuron blocks in parallel, so one pass over the axons integrates NUM_LANES neurons at once.
- Replaces the file-initialised instruction table with a runtime write port, removes negedge counters (single posedge domain) and adds a done pulse.
- Sits between the scheduler SRAM, the CSRAM and the per-lane neuron blocks. Spikes exit towards the router local buffers.

Parameters:
- NUM_AXONS, 256, axons per core; power of two, ≥2.
- NUM_NEURONS, 256, neurons per core; must be divisible by NUM_LANES.
- NUM_WEIGHTS, 4, weight types; instruction width IW = $clog2(NUM_WEIGHTS).
- NUM_LANES, 4, neurons processed in parallel; NUM_GROUPS = NUM_NEURONS/NUM_LANES.

Ports:
- clk  in  1  single clock, posedge only.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  starts one timestep.
- axon_spikes  in  NUM_AXONS  scheduler row for the current tick.
- synapses  in  NUM_LANES*NUM_AXONS  CSRAM connectivity; lane l occupies bits [l*NUM_AXONS +: NUM_AXONS].
- spike_in  in  NUM_LANES  per-lane threshold result from the neuron blocks.
- local_buffers_full  in  1  router backpressure.
- instr_we  in  1  instruction table write enable.
- instr_addr  in  $clog2(NUM_AXONS)  table index.
- instr_wdata  in  IW  axon weight type.
- error  out  1  sticky tick-overrun flag.
- scheduler_set, scheduler_clr  out  1 each  scheduler pointer advance / clear.
- CSRAM_write  out  1  write back the group's potentials.
- CSRAM_addr  out  $clog2(NUM_GROUPS) (min 1)  neuron group index.
- neuron_instruction  out  IW  weight select, shared by all lanes.
- neuron_reg_en  out  NUM_LANES  per-lane integrate enable.
- write_current_potential  out  NUM_LANES  per-lane load of the stored potential.
- next_neuron  out  1  start of a new group.
- spike_out  out  NUM_LANES  spikes to the router.
- done  out  1  one-cycle end-of-tick pulse.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, row=0, all outputs 0. The instruction table is not reset.
- rst mid-operation: abandons the pass next edge with no scheduler_clr and no done.
- Every output is registered. "In state S" means the value registered at the posedge while in S.
- IDLE:
  - drives scheduler_clr=0 and done=0;
  - a write with instr_we=1 sets table[instr_addr]=instr_wdata;
  - tick moves to SET_SCHED.
- instr_we outside IDLE is ignored.
- tick outside IDLE sets error=1, which holds until rst; the FSM ignores that tick.
- SET_SCHED: scheduler_set=1 (one cycle), CSRAM_addr=0, row=0, then FIRST_AXON.
- FIRST_AXON (axon 0), for each lane l:
  - set hit_l = axon_spikes[0] & syn_l[0];
  - drive neuron_reg_en[l]=1 and write_current_potential[l]=!hit_l;
  - drive next_neuron=1, neuron_instruction=table[0], scheduler_set=0, row=1;
  - then INTEGRATE.
- INTEGRATE (axon = row):
  - drive next_neuron=0, write_current_potential=0, neuron_reg_en[l]=axon_spikes[row]&syn_l[row], neuron_instruction=table[row];
  - if row==NUM_AXONS-1, go to WRITE_CSRAM; else row+1.
- WRITE_CSRAM: neuron_reg_en=0.
  - If |spike_in and local_buffers_full: stay, with spike_out=0 and CSRAM_write=0.
  - Otherwise: spike_out=spike_in (all lanes in the same cycle), CSRAM_write=1, then GROUP_CHECK.
- GROUP_CHECK: spike_out=0, CSRAM_write=0.
  - If CSRAM_addr==NUM_GROUPS-1, go to CLR_SCHED.
  - Otherwise CSRAM_addr+1, row=0, then FIRST_AXON.
- CLR_SCHED: scheduler_clr=1 and done=1 for one cycle, then IDLE.
- Latency without the optional feature and with no stalls: tick→done = 3 + NUM_GROUPS*(NUM_AXONS+2) cycles.
- Arithmetic:
  - row is $clog2(NUM_AXONS)+1 bits and never wraps.
  - CSRAM_addr does not wrap; it stops at NUM_GROUPS-1.

Optional Feature:
- Macro: TC_AXON_SKIP_EN.
- Defined:
  - INTEGRATE jumps row to the next index greater than the current one with axon_spikes set;
  - if none is left, it goes to WRITE_CSRAM after the current axon;
  - FIRST_AXON still always processes axon 0;
  - per-group cycles become 2 + 1 + (number of set axon bits above 0).
- Undefined: the exhaustive per-axon scan described in Behaviour.

Decomposition:
- Package tc_pkg holds:
  - the state enum (IDLE, SET_SCHED, FIRST_AXON, INTEGRATE, WRITE_CSRAM, GROUP_CHECK, CLR_SCHED);
  - the width helper functions for IW, group and row widths.
- One sub-module, tc_next_active_axon: combinational priority encoder (spikes, current row → next row, valid). It is instantiated only under TC_AXON_SKIP_EN.

Test Plan:
Bench parameters for all scenarios: NUM_AXONS=8, NUM_NEURONS=4, NUM_LANES=2.
- Load table=0..3 repeating; axon_spikes=8'b0000_0101, all synapses 1; tick → neuron_reg_en=2'b11 at axons 0 and 2 only, instruction 0 then 2; done 23 cycles after tick.
- Lane 1 synapses=0 on axon 0, lane 0=1, spikes[0]=1 → FIRST_AXON write_current_potential=2'b10.
- spike_in=2'b01 with local_buffers_full held high 5 cycles → stays in WRITE_CSRAM 5 cycles, then spike_out=2'b01 and CSRAM_write=1 in the same cycle.
- tick reasserted during INTEGRATE → error=1 stays high through done; cleared only by rst; FSM completes normally.
- rst during group 1 → all outputs 0 the next cycle; no scheduler_clr; a later tick restarts at CSRAM_addr=0.
- With TC_AXON_SKIP_EN and spikes=8'b1000_0001 → per group FIRST_AXON, one INTEGRATE cycle (axon 7), WRITE, CHECK; done 11 cycles after tick.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and width helpers for the multi-lane token controller.
package tc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_SCHED,
    FIRST_AXON,
    INTEGRATE,
    WRITE_CSRAM,
    GROUP_CHECK,
    CLR_SCHED
  } tc_state_t;

  // Width of the weight-type instruction; never narrower than one bit.
  function automatic int instr_width(input int num_weights);
    return (num_weights > 1) ? $clog2(num_weights) : 1;
  endfunction

  // Width of the neuron-group (CSRAM) address; never narrower than one bit.
  function automatic int group_width(input int num_groups);
    return (num_groups > 1) ? $clog2(num_groups) : 1;
  endfunction

  // Row counter carries one spare bit above the axon index.
  function automatic int row_width(input int num_axons);
    return $clog2(num_axons) + 1;
  endfunction

endpackage

// File: rtl/tc_next_active_axon.sv
// Finds the lowest set axon strictly above the current row.
module tc_next_active_axon
  import tc_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  localparam int RW = row_width(NUM_AXONS)
) (
  input  logic [NUM_AXONS-1:0] spikes,
  input  logic [RW-1:0]        row,
  output logic [RW-1:0]        next_row,
  output logic                 valid
);

  // Scan from the top down so the lowest qualifying index is the last one kept.
  always_comb begin
    next_row = '0;
    valid    = 1'b0;
    for (int i = NUM_AXONS - 1; i >= 0; i--) begin
      if (spikes[i] && (RW'(i) > row)) begin
        next_row = RW'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/token_controller_lanes.sv
// Multi-lane token controller: sweeps the axons once per neuron group and
// drives NUM_LANES neuron blocks in parallel. Optional TC_AXON_SKIP_EN makes
// the sweep jump straight to the next spiking axon instead of visiting all.
module token_controller_lanes
  import tc_pkg::*;
#(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int NUM_WEIGHTS = 4,
  parameter int NUM_LANES   = 4,
  localparam int NUM_GROUPS = NUM_NEURONS / NUM_LANES,
  localparam int IW         = instr_width(NUM_WEIGHTS),
  localparam int GW         = group_width(NUM_GROUPS),
  localparam int AW         = $clog2(NUM_AXONS),
  localparam int RW         = row_width(NUM_AXONS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [NUM_AXONS-1:0]           axon_spikes,
  input  logic [NUM_LANES*NUM_AXONS-1:0] synapses,
  input  logic [NUM_LANES-1:0]           spike_in,
  input  logic                           local_buffers_full,
  input  logic                           instr_we,
  input  logic [AW-1:0]                  instr_addr,
  input  logic [IW-1:0]                  instr_wdata,
  output logic                           error,
  output logic                           scheduler_set,
  output logic                           scheduler_clr,
  output logic                           CSRAM_write,
  output logic [GW-1:0]                  CSRAM_addr,
  output logic [IW-1:0]                  neuron_instruction,
  output logic [NUM_LANES-1:0]           neuron_reg_en,
  output logic [NUM_LANES-1:0]           write_current_potential,
  output logic                           next_neuron,
  output logic [NUM_LANES-1:0]           spike_out,
  output logic                           done
);

  tc_state_t            state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [AW-1:0]        ax;
  logic [NUM_LANES-1:0] hit;
  logic [IW-1:0]        instr_table [NUM_AXONS];

  logic                 err_d, sset_d, sclr_d, cw_d, nn_d, done_d;
  logic [GW-1:0]        addr_d;
  logic [IW-1:0]        instr_d;
  logic [NUM_LANES-1:0] reg_en_d, wcp_d, so_d;

  assign ax = row_q[AW-1:0];

  // Each lane integrates when the current axon spiked and the lane is connected to it.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [NUM_AXONS-1:0] syn_l;
    assign syn_l  = synapses[l*NUM_AXONS +: NUM_AXONS];
    assign hit[l] = axon_spikes[ax] & syn_l[ax];
  end

`ifdef TC_AXON_SKIP_EN
  logic [RW-1:0] skip_row;
  logic          skip_vld;

  tc_next_active_axon #(.NUM_AXONS(NUM_AXONS)) u_next_active_axon (
    .spikes   (axon_spikes),
    .row      (row_q),
    .next_row (skip_row),
    .valid    (skip_vld)
  );
`endif

  // Instruction table is loaded only while idle and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && instr_we) begin
      instr_table[instr_addr] <= instr_wdata;
    end
  end

  // Next-state and next-output decode; pulse outputs default low, addresses hold.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    addr_d   = CSRAM_addr;
    instr_d  = neuron_instruction;
    err_d    = error;
    sset_d   = 1'b0;
    sclr_d   = 1'b0;
    cw_d     = 1'b0;
    nn_d     = 1'b0;
    done_d   = 1'b0;
    reg_en_d = '0;
    wcp_d    = '0;
    so_d     = '0;

    if (tick && state_q != IDLE) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SET_SCHED;
        end
      end
      SET_SCHED: begin
        sset_d  = 1'b1;
        addr_d  = '0;
        row_d   = '0;
        state_d = FIRST_AXON;
      end
      FIRST_AXON: begin
        reg_en_d = '1;
        wcp_d    = ~hit;
        nn_d     = 1'b1;
        instr_d  = instr_table[0];
`ifdef TC_AXON_SKIP_EN
        row_d    = skip_row;
        state_d  = skip_vld ? INTEGRATE : WRITE_CSRAM;
`else
        row_d    = RW'(1);
        state_d  = INTEGRATE;
`endif
      end
      INTEGRATE: begin
        reg_en_d = hit;
        instr_d  = instr_table[ax];
`ifdef TC_AXON_SKIP_EN
        if (skip_vld) begin
          row_d = skip_row;
        end else begin
          state_d = WRITE_CSRAM;
        end
`else
        if (row_q == RW'(NUM_AXONS - 1)) begin
          state_d = WRITE_CSRAM;
        end else begin
          row_d = row_q + RW'(1);
        end
`endif
      end
      WRITE_CSRAM: begin
        if (!(|spike_in && local_buffers_full)) begin
          so_d    = spike_in;
          cw_d    = 1'b1;
          state_d = GROUP_CHECK;
        end
      end
      GROUP_CHECK: begin
        if (CSRAM_addr == GW'(NUM_GROUPS - 1)) begin
          state_d = CLR_SCHED;
        end else begin
          addr_d  = CSRAM_addr + GW'(1);
          row_d   = '0;
          state_d = FIRST_AXON;
        end
      end
      CLR_SCHED: begin
        sclr_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything except the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IDLE;
      row_q                   <= '0;
      error                   <= 1'b0;
      scheduler_set           <= 1'b0;
      scheduler_clr           <= 1'b0;
      CSRAM_write             <= 1'b0;
      CSRAM_addr              <= '0;
      neuron_instruction      <= '0;
      neuron_reg_en           <= '0;
      write_current_potential <= '0;
      next_neuron             <= 1'b0;
      spike_out               <= '0;
      done                    <= 1'b0;
    end else begin
      state_q                 <= state_d;
      row_q                   <= row_d;
      error                   <= err_d;
      scheduler_set           <= sset_d;
      scheduler_clr           <= sclr_d;
      CSRAM_write             <= cw_d;
      CSRAM_addr              <= addr_d;
      neuron_instruction      <= instr_d;
      neuron_reg_en           <= reg_en_d;
      write_current_potential <= wcp_d;
      next_neuron             <= nn_d;
      spike_out               <= so_d;
      done                    <= done_d;
    end
  end

endmodule

// File: tb/tb_token_controller_lanes.sv
// Self-checking bench for token_controller_lanes (8 axons, 4 neurons, 2 lanes).
// Expected per-cycle outputs are derived from the timestep schedule rules.
module tb_token_controller_lanes;

  localparam int A  = 8;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int L  = 2;
  localparam int G  = N / L;
  localparam int IW = 2;
  localparam int AW = 3;
  localparam int GW = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick = 1'b0;
  logic [A-1:0]   axon_spikes = '0;
  logic [L*A-1:0] synapses = '0;
  logic [L-1:0]   spike_in = '0;
  logic           local_buffers_full = 1'b0;
  logic           instr_we = 1'b0;
  logic [AW-1:0]  instr_addr = '0;
  logic [IW-1:0]  instr_wdata = '0;
  logic           error, scheduler_set, scheduler_clr, CSRAM_write, next_neuron, done;
  logic [GW-1:0]  CSRAM_addr;
  logic [IW-1:0]  neuron_instruction;
  logic [L-1:0]   neuron_reg_en, write_current_potential, spike_out;

  token_controller_lanes #(
    .NUM_AXONS(A), .NUM_NEURONS(N), .NUM_WEIGHTS(W), .NUM_LANES(L)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .axon_spikes(axon_spikes),
    .synapses(synapses), .spike_in(spike_in),
    .local_buffers_full(local_buffers_full), .instr_we(instr_we),
    .instr_addr(instr_addr), .instr_wdata(instr_wdata), .error(error),
    .scheduler_set(scheduler_set), .scheduler_clr(scheduler_clr),
    .CSRAM_write(CSRAM_write), .CSRAM_addr(CSRAM_addr),
    .neuron_instruction(neuron_instruction), .neuron_reg_en(neuron_reg_en),
    .write_current_potential(write_current_potential),
    .next_neuron(next_neuron), .spike_out(spike_out), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [IW-1:0] tbl_m [A];
  logic [GW-1:0] addr_m = '0;
  logic [IW-1:0] instr_m = '0;
  bit            err_m = 1'b0;
  logic [15:0]   exp_q [$];
  int            full_q [$];
  bit            fix_q [$];
  logic [L-1:0]  spin_cur = '0;
  int            mid_n = 0;
  int            lat_m = 0;

  function automatic logic [15:0] pack(input logic e, input logic ss, input logic sc,
                                       input logic cw, input logic [GW-1:0] ad,
                                       input logic [IW-1:0] ins, input logic [L-1:0] re,
                                       input logic [L-1:0] wcp, input logic nn,
                                       input logic [L-1:0] so, input logic dn);
    return {1'b0, e, ss, sc, cw, ad, ins, re, wcp, nn, so, dn};
  endfunction

  function automatic logic [15:0] obs();
    return pack(error, scheduler_set, scheduler_clr, CSRAM_write, CSRAM_addr,
                neuron_instruction, neuron_reg_en, write_current_potential,
                next_neuron, spike_out, done);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, o, e, $time);
    end
  endtask

  // Append one expected cycle; full: 0/1 forced, 2 = random. fix: spike_in held.
  task automatic push(input logic ss, input logic sc, input logic cw,
                      input logic [L-1:0] re, input logic [L-1:0] wcp, input logic nn,
                      input logic [L-1:0] so, input logic dn, input int full, input bit fix);
    logic e;
    e = err_m || (mid_n > 0 && (exp_q.size() + 1) >= mid_n);
    exp_q.push_back(pack(e, ss, sc, cw, addr_m, instr_m, re, wcp, nn, so, dn));
    full_q.push_back(full);
    fix_q.push_back(fix);
  endtask

  // Build the expected cycle list for one timestep.
  task automatic build(input logic [A-1:0] spk, input logic [L*A-1:0] syn,
                       input logic [L-1:0] spin, input int st0, input int st1, input int mid);
    int axl [$];
    int stall;
    int a;
    logic [L-1:0] hit;
    exp_q.delete(); full_q.delete(); fix_q.delete();
    axon_spikes = spk;
    synapses    = syn;
    spin_cur    = spin;
    mid_n       = mid;
    push(0, 0, 0, '0, '0, 0, '0, 0, 2, 0);
    addr_m = '0;
    push(1, 0, 0, '0, '0, 0, '0, 0, 2, 0);
    axl.push_back(0);
    for (int k = 1; k < A; k++) begin
`ifdef TC_AXON_SKIP_EN
      if (spk[k]) axl.push_back(k);
`else
      axl.push_back(k);
`endif
    end
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < axl.size(); k++) begin
        a = axl[k];
        for (int l = 0; l < L; l++) hit[l] = spk[a] & syn[l*A + a];
        instr_m = tbl_m[a];
        if (a == 0) push(0, 0, 0, '1, ~hit, 1, '0, 0, 2, 0);
        else        push(0, 0, 0, hit, '0, 0, '0, 0, 2, 0);
      end
      stall = (spin != '0) ? ((g == 0) ? st0 : st1) : 0;
      for (int s = 0; s < stall; s++) push(0, 0, 0, '0, '0, 0, '0, 0, 1, 1);
      push(0, 0, 1, '0, '0, 0, spin, 0, 0, 1);
      if (g < G - 1) addr_m = addr_m + 1'b1;
      push(0, 0, 0, '0, '0, 0, '0, 0, 2, 0);
    end
    push(0, 1, 0, '0, '0, 0, '0, 1, 2, 0);
    push(0, 0, 0, '0, '0, 0, '0, 0, 2, 0);
    lat_m = 3 + G * (2 + axl.size()) + ((spin != '0) ? (st0 + st1) : 0);
    if (mid > 0) err_m = 1'b1;
  endtask

  // Replay the expected list cycle by cycle; abort_at > 0 stops early.
  task automatic run(input string tag, input int abort_at);
    int done_n;
    done_n = 0;
    for (int n = 1; n <= exp_q.size(); n++) begin
      tick = (n == 1) || (n == mid_n);
      if (full_q[n-1] == 2) local_buffers_full = 1'($urandom_range(0, 1));
      else                  local_buffers_full = (full_q[n-1] == 1);
      spike_in = fix_q[n-1] ? spin_cur : L'($urandom);
      if (n > 1 && n < exp_q.size()) begin
        instr_we    = 1'($urandom_range(0, 1));
        instr_addr  = AW'($urandom);
        instr_wdata = IW'($urandom);
      end else begin
        instr_we = 1'b0;
      end
      @(posedge clk); #1;
      chk(tag, 32'(obs()), 32'(exp_q[n-1]));
      if (done && done_n == 0) done_n = n;
      if (abort_at == n) break;
    end
    tick = 1'b0;
    instr_we = 1'b0;
    local_buffers_full = 1'b0;
    if (abort_at == 0) chk({tag, "_latency"}, done_n, lat_m);
  endtask

  task automatic load_table(input bit rnd);
    for (int i = 0; i < A; i++) begin
      instr_we    = 1'b1;
      instr_addr  = AW'(i);
      instr_wdata = rnd ? IW'($urandom) : IW'(i % 4);
      tbl_m[i]    = instr_wdata;
      @(posedge clk); #1;
      chk("table_load_idle", 32'(obs()), 32'(pack(err_m, 0, 0, 0, addr_m, instr_m, '0, '0, 0, '0, 0)));
    end
    instr_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'h0);
    rst = 1'b0;

    load_table(0);

    build(8'b0000_0101, '1, '0, 0, 0, 0);
    run("basic_0101", 0);

    build(8'b0000_0011, {8'hFE, 8'hFF}, '0, 0, 0, 0);
    run("lane_wcp", 0);

    build(8'h5A, L*A'($urandom), 2'b01, 5, 2, 0);
    run("stall_full", 0);

    build(8'h0F, '1, 2'b11, 0, 0, 5);
    run("tick_overrun", 0);
    build(8'h33, '1, 2'b10, 1, 0, 0);
    run("error_holds", 0);

    build(8'hFF, '1, 2'b11, 0, 0, 0);
    run("rst_mid", 3 + (A + 2) + 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_clear", 32'(obs()), 32'h0);
    rst = 1'b0;
    addr_m = '0; instr_m = '0; err_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_quiet", 32'(obs()), 32'h0);
    end
    build(8'h81, '1, '0, 0, 0, 0);
    run("restart", 0);

    build(8'b1000_0001, '1, 2'b01, 0, 0, 0);
    run("spikes_81", 0);

    for (int it = 0; it < 16; it++) begin
      if (it % 4 == 0) load_table(1);
      build(A'($urandom), (L*A)'($urandom), L'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), 0);
      run("random", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
